// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes "$f0,f1,...\r\n" ASCII frames from a UART byte
// stream into up to MAX_FIELDS unsigned decimal fields.
// Optional build macro UART_CMD_STATS_EN adds saturating command/error counters.
module uart_cmd_parser #(
    parameter int unsigned MAX_FIELDS = 3,
    parameter int unsigned FIELD_W    = 16
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [2:0]                    cmd_nfields,
    output logic [MAX_FIELDS*FIELD_W-1:0] cmd_fields,
    output logic                          err_pulse,
    output logic [2:0]                    err_code
`ifdef UART_CMD_STATS_EN
    ,
    output logic [15:0]                   cmd_ok_cnt,
    output logic [15:0]                   cmd_err_cnt
`endif
);

    localparam int unsigned DATA_W = MAX_FIELDS * FIELD_W;
    localparam int unsigned ACC_W  = FIELD_W + 4;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_SP     = 8'h20;

    localparam logic [2:0] E_BAD_CHAR    = 3'd1;
    localparam logic [2:0] E_EMPTY_FIELD = 3'd2;
    localparam logic [2:0] E_TOO_MANY    = 3'd3;
    localparam logic [2:0] E_OVERFLOW    = 3'd4;
    localparam logic [2:0] E_NO_LF       = 3'd5;
    localparam logic [2:0] E_OVERRUN     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIELD,
        S_CR_SEEN,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t              state_q, state_d;
    logic [FIELD_W-1:0]  acc_q, acc_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                digit_seen_q, digit_seen_d;
    logic [DATA_W-1:0]   fields_q, fields_d;
    logic                cmd_valid_d;
    logic [2:0]          cmd_nfields_d;
    logic [DATA_W-1:0]   cmd_fields_d;
    logic                err_pulse_d;
    logic [2:0]          err_code_d;

    logic                is_digit_c;
    logic [3:0]          digit_c;
    logic [ACC_W-1:0]    acc_ext_c;
    logic                acc_ovf_c;
    logic                cnt_full_c;
    logic                restart_c;
    logic                store_c;
    logic                raise_c;
    logic [2:0]          raise_code_c;

    // Decimal digit decode and widened accumulate for overflow detection
    always_comb begin
        is_digit_c = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        digit_c    = 4'(rx_data - 8'h30);
        acc_ext_c  = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(digit_c);
        acc_ovf_c  = |acc_ext_c[ACC_W-1:FIELD_W];
        cnt_full_c = (cnt_q == 3'(MAX_FIELDS));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        digit_seen_d  = digit_seen_q;
        fields_d      = fields_q;
        cmd_valid_d   = cmd_valid;
        cmd_nfields_d = cmd_nfields;
        cmd_fields_d  = cmd_fields;
        err_pulse_d   = 1'b0;
        err_code_d    = 3'd0;
        restart_c     = 1'b0;
        store_c       = 1'b0;
        raise_c       = 1'b0;
        raise_code_c  = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == CH_DOLLAR) restart_c = 1'b1;
            end
            S_FIELD: begin
                if (rx_valid) begin
                    if (rx_data == CH_DOLLAR) begin
                        restart_c = 1'b1;
                    end else if (rx_data == CH_SP) begin
                        state_d = S_FIELD;
                    end else if (is_digit_c) begin
                        acc_d        = acc_ext_c[FIELD_W-1:0];
                        digit_seen_d = 1'b1;
                        if (acc_ovf_c) begin
                            raise_c      = 1'b1;
                            raise_code_c = E_OVERFLOW;
                        end
                    end else if (rx_data == CH_COMMA) begin
                        if (!digit_seen_q) begin
                            raise_c      = 1'b1;
                            raise_code_c = E_EMPTY_FIELD;
                        end else if (cnt_full_c) begin
                            raise_c      = 1'b1;
                            raise_code_c = E_TOO_MANY;
                        end else begin
                            store_c      = 1'b1;
                            acc_d        = '0;
                            digit_seen_d = 1'b0;
                        end
                    end else if (rx_data == CH_CR) begin
                        if (digit_seen_q) begin
                            if (cnt_full_c) begin
                                raise_c      = 1'b1;
                                raise_code_c = E_TOO_MANY;
                            end else begin
                                store_c = 1'b1;
                                state_d = S_CR_SEEN;
                            end
                        end else if (cnt_q != 3'd0) begin
                            raise_c      = 1'b1;
                            raise_code_c = E_EMPTY_FIELD;
                        end else begin
                            state_d = S_CR_SEEN;
                        end
                    end else begin
                        raise_c      = 1'b1;
                        raise_code_c = E_BAD_CHAR;
                    end
                end
            end
            S_CR_SEEN: begin
                if (rx_valid) begin
                    if (rx_data == CH_LF) begin
                        state_d       = S_HOLD;
                        cmd_valid_d   = 1'b1;
                        cmd_nfields_d = cnt_q;
                        cmd_fields_d  = fields_q;
                    end else if (rx_data == CH_DOLLAR) begin
                        restart_c = 1'b1;
                    end else if (rx_data != CH_SP) begin
                        raise_c      = 1'b1;
                        raise_code_c = E_NO_LF;
                    end
                end
            end
            S_HOLD: begin
                // Bytes arriving while a command is pending are lost
                if (rx_valid) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = E_OVERRUN;
                end
                if (cmd_valid && cmd_ready) begin
                    cmd_valid_d   = 1'b0;
                    cmd_nfields_d = 3'd0;
                    cmd_fields_d  = '0;
                    state_d       = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (rx_valid) begin
                    if (rx_data == CH_LF) state_d = S_IDLE;
                    else if (rx_data == CH_DOLLAR) restart_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (store_c) begin
            for (int i = 0; i < int'(MAX_FIELDS); i++) begin
                if (cnt_q == 3'(i)) fields_d[i*FIELD_W +: FIELD_W] = acc_q;
            end
            cnt_d = cnt_q + 3'd1;
        end
        if (restart_c) begin
            acc_d        = '0;
            cnt_d        = 3'd0;
            digit_seen_d = 1'b0;
            fields_d     = '0;
            state_d      = S_FIELD;
        end
        if (raise_c) begin
            err_pulse_d = 1'b1;
            err_code_d  = raise_code_c;
            state_d     = S_DISCARD;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= 3'd0;
            digit_seen_q <= 1'b0;
            fields_q     <= '0;
            cmd_valid    <= 1'b0;
            cmd_nfields  <= 3'd0;
            cmd_fields   <= '0;
            err_pulse    <= 1'b0;
            err_code     <= 3'd0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            digit_seen_q <= digit_seen_d;
            fields_q     <= fields_d;
            cmd_valid    <= cmd_valid_d;
            cmd_nfields  <= cmd_nfields_d;
            cmd_fields   <= cmd_fields_d;
            err_pulse    <= err_pulse_d;
            err_code     <= err_code_d;
        end
    end

`ifdef UART_CMD_STATS_EN
    // Saturating counts of accepted commands and reported errors
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_ok_cnt  <= 16'd0;
            cmd_err_cnt <= 16'd0;
        end else begin
            if (cmd_valid && cmd_ready && cmd_ok_cnt != 16'hFFFF)
                cmd_ok_cnt <= cmd_ok_cnt + 16'd1;
            if (err_pulse && cmd_err_cnt != 16'hFFFF)
                cmd_err_cnt <= cmd_err_cnt + 16'd1;
        end
    end
`endif

endmodule
